// File: rtl/edge_detection_pkg.sv
// Shared constants, FSM state type and Sobel kernel tables for the edge detector.
package edge_detection_pkg;

    localparam int IMG_W = 640;
    localparam int IMG_H = 480;
    localparam int CW    = 11;
    localparam int ACC_W = 12;

    localparam logic [ACC_W-1:0] SAT_MAX = 12'd1023;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } state_t;

    // Tap index = row*3 + col, row = dy+1 (top row first), col = dx+1.
    localparam logic signed [2:0] GX_W [9] = '{
        -3'sd1, 3'sd0, 3'sd1,
        -3'sd2, 3'sd0, 3'sd2,
        -3'sd1, 3'sd0, 3'sd1
    };

    localparam logic signed [2:0] GY_W [9] = '{
        -3'sd1, -3'sd2, -3'sd1,
         3'sd0,  3'sd0,  3'sd0,
         3'sd1,  3'sd2,  3'sd1
    };

endpackage

// File: rtl/edge_detection_top_sobel_mac.sv
// Sobel multiply-accumulate: sums Gx/Gy over the 9 taps and produces the
// saturated |Gx|+|Gy| combinationally alongside the final tap.
module sobel_mac #(
    parameter int OUT_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             last_i,
    input  logic [3:0]       tap_i,
    input  logic [7:0]       sample_i,
    output logic [OUT_W-1:0] mag_o
);
    import edge_detection_pkg::*;

    logic signed [ACC_W-1:0] gx_q, gy_q;
    logic signed [ACC_W-1:0] samp, gx_sum, gy_sum;
    logic        [ACC_W-1:0] gx_abs, gy_abs, mag;

    assign samp   = {{(ACC_W-8){1'b0}}, sample_i};
    assign gx_sum = gx_q + samp * ACC_W'(GX_W[tap_i]);
    assign gy_sum = gy_q + samp * ACC_W'(GY_W[tap_i]);

    assign gx_abs = gx_sum[ACC_W-1] ? -gx_sum : gx_sum;
    assign gy_abs = gy_sum[ACC_W-1] ? -gy_sum : gy_sum;
    assign mag    = gx_abs + gy_abs;
    assign mag_o  = (mag > SAT_MAX) ? OUT_W'(SAT_MAX) : OUT_W'(mag);

    // Accumulators restart on the final tap so the next pixel begins clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            gx_q <= '0;
            gy_q <= '0;
        end else if (valid_i) begin
            gx_q <= last_i ? '0 : gx_sum;
            gy_q <= last_i ? '0 : gy_sum;
        end
    end

endmodule

// File: rtl/edge_detection_top.sv
// Raster-order Sobel edge detector: walks each output pixel's 3x3 window one
// fetch per cycle and emits one saturated magnitude per 9 completed fetches.
module edge_detection_top #(
    parameter int IMG_W = edge_detection_pkg::IMG_W,
    parameter int IMG_H = edge_detection_pkg::IMG_H,
    parameter int CW    = edge_detection_pkg::CW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 waitrequest,
    input  logic [7:0]           pixel,
    output logic signed [CW-1:0] next_pixel_x,
    output logic signed [CW-1:0] next_pixel_y,
    output logic                 readValid,
    output logic signed [CW-1:0] pixel_out_x,
    output logic signed [CW-1:0] pixel_out_y,
    output logic signed [CW-1:0] pixel_out,
    output logic                 sync
);
    import edge_detection_pkg::*;

    state_t               state_q, state_d;
    logic signed [CW-1:0] x_q, x_d, y_q, y_d;
    logic        [1:0]    col_q, col_d, row_q, row_d;
    logic                 sync_q, sync_d;
    logic                 rv_q;
    logic signed [CW-1:0] po_q, pox_q, poy_q;

    logic                 fire, last_tap, frame_end, oob;
    logic signed [CW-1:0] nx, ny;
    logic        [3:0]    tap;
    logic        [7:0]    sample;
    logic        [CW-1:0] mag;

    // Counters sit at zero in IDLE/DONE, so the window origin reads (-1,-1).
    assign nx  = x_q + CW'(col_q) - CW'(1);
    assign ny  = y_q + CW'(row_q) - CW'(1);
    assign tap = 4'(row_q) * 4'd3 + 4'(col_q);

    assign oob = nx[CW-1] || ny[CW-1] || (nx >= CW'(IMG_W)) || (ny >= CW'(IMG_H));
    assign sample = oob ? 8'd0 : pixel;

    assign last_tap  = (col_q == 2'd2) && (row_q == 2'd2);
    assign frame_end = last_tap && (x_q == CW'(IMG_W-1)) && (y_q == CW'(IMG_H-1));

    always_comb begin
        state_d = state_q;
        sync_d  = sync_q;
        fire    = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        row_d   = row_q;

        case (state_q)
            IDLE: begin
                fire = en && !waitrequest;
                if (fire) state_d = FETCH;
            end
            FETCH: begin
                fire = en && !waitrequest;
                if (fire && frame_end) state_d = DONE;
            end
            DONE: begin
                if (en) begin
                    sync_d = 1'b1;
                end else begin
                    sync_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fire) begin
            if (col_q == 2'd2) begin
                col_d = '0;
                if (row_q == 2'd2) begin
                    row_d = '0;
                    if (x_q == CW'(IMG_W-1)) begin
                        x_d = '0;
                        y_d = (y_q == CW'(IMG_H-1)) ? '0 : y_q + CW'(1);
                    end else begin
                        x_d = x_q + CW'(1);
                    end
                end else begin
                    row_d = row_q + 2'd1;
                end
            end else begin
                col_d = col_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            row_q   <= '0;
            sync_q  <= 1'b0;
            rv_q    <= 1'b0;
            po_q    <= '0;
            pox_q   <= '0;
            poy_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            row_q   <= row_d;
            sync_q  <= sync_d;
            rv_q    <= fire && last_tap;
            if (fire && last_tap) begin
                po_q  <= mag;
                pox_q <= x_q;
                poy_q <= y_q;
            end
        end
    end

    sobel_mac #(
        .OUT_W (CW)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (fire),
        .last_i   (last_tap),
        .tap_i    (tap),
        .sample_i (sample),
        .mag_o    (mag)
    );

    assign next_pixel_x = nx;
    assign next_pixel_y = ny;
    assign readValid    = rv_q;
    assign pixel_out    = po_q;
    assign pixel_out_x  = pox_q;
    assign pixel_out_y  = poy_q;
    assign sync         = sync_q;

endmodule

// File: tb/tb_edge_detection_top.sv
// Directed bench for edge_detection_top on a reduced 16x12 image; pixel data
// comes from coordinate-based patterns with hand-computed Sobel results.
module tb_edge_detection_top;

    localparam int W  = 16;
    localparam int H  = 12;
    localparam int CW = 11;

    logic                 clk = 1'b0;
    logic                 rst, en, wr;
    logic [7:0]           pixel;
    logic signed [CW-1:0] nx, ny, pox, poy, po;
    logic                 rv, sync;

    int mode;
    int cyc = 0;
    int start_cyc = 0;
    int base, sync_cyc, frame_n;
    int n_rv = 0;
    int last_x, last_y, last_cyc, last_val;
    int res_val [W*H];
    int res_cyc [W*H];
    int n_chk = 0;
    int n_err = 0;
    int px, py;
    int sv_x, sv_y, sv_po;

    always #5 clk = ~clk;

    edge_detection_top #(
        .IMG_W (W),
        .IMG_H (H),
        .CW    (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .waitrequest  (wr),
        .pixel        (pixel),
        .next_pixel_x (nx),
        .next_pixel_y (ny),
        .readValid    (rv),
        .pixel_out_x  (pox),
        .pixel_out_y  (poy),
        .pixel_out    (po),
        .sync         (sync)
    );

    function automatic logic [7:0] img(input int m, input int x, input int y);
        case (m)
            0:       return 8'd100;
            1:       return (x >= W/2) ? 8'd255 : 8'd0;
            2:       return (x + y >= 20) ? 8'd255 : 8'd0;
            default: return 8'((x*7 + y*13) & 255);
        endcase
    endfunction

    // Junk outside the image and during stalls; the DUT must never use it.
    assign px = nx;
    assign py = ny;
    assign pixel = (wr || px < 0 || px >= W || py < 0 || py >= H) ? 8'hAB : img(mode, px, py);

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rv) begin
            n_rv     <= n_rv + 1;
            last_x   <= int'(pox);
            last_y   <= int'(poy);
            last_val <= int'(po);
            last_cyc <= cyc - start_cyc;
            if (pox >= 0 && pox < W && poy >= 0 && poy < H) begin
                res_val[int'(poy)*W + int'(pox)] <= int'(po);
                res_cyc[int'(poy)*W + int'(pox)] <= cyc - start_cyc;
            end
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic run_frame(input int m, input bit disturb);
        rst = 1'b1; en = 1'b0; wr = 1'b0; mode = m;
        tick;
        rst = 1'b0;
        base = n_rv; start_cyc = cyc; en = 1'b1;
        if (disturb) begin
            // Fetch 22 is fetch 4 (centre) of pixel (2,0); stall it 3 cycles.
            repeat (22) tick;
            chk("stall_nx_pre", nx, 2);
            chk("stall_ny_pre", ny, 0);
            wr = 1'b1;
            repeat (3) tick;
            chk("stall_nx_hold", nx, 2);
            chk("stall_ny_hold", ny, 0);
            wr = 1'b0;
            repeat (35) tick;
            sv_x = nx; sv_y = ny; sv_po = po;
            en = 1'b0;
            tick;
            chk("pause_rv0", rv, 0);
            chk("pause_nx", nx, sv_x);
            tick;
            chk("pause_ny", ny, sv_y);
            chk("pause_po", po, sv_po);
            en = 1'b1;
        end
        sync_cyc = -1;
        for (int i = 0; i < 9*W*H + 60; i++) begin
            tick;
            if (sync) begin
                sync_cyc = cyc - start_cyc;
                break;
            end
        end
        frame_n = n_rv - base;
        en = 1'b0;
        tick;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; wr = 1'b0; mode = 0;
        tick;
        tick;
        chk("rst_rv", rv, 0);
        chk("rst_sync", sync, 0);
        chk("rst_po", po, 0);
        chk("rst_pox", pox, 0);
        chk("rst_poy", poy, 0);
        chk("rst_nx", nx, -1);
        chk("rst_ny", ny, -1);

        run_frame(0, 1'b0);
        chk("uni_0_0", res_val[0], 600);
        chk("uni_5_5", res_val[5*W+5], 0);
        chk("uni_corner", res_val[W*H-1], 600);
        chk("uni_count", frame_n, W*H);
        chk("uni_last_x", last_x, W-1);
        chk("uni_last_y", last_y, H-1);
        chk("uni_last_cyc", last_cyc, 9*W*H);
        chk("uni_sync_cyc", sync_cyc, 9*W*H + 1);
        chk("uni_sync_drop", sync, 0);
        chk("uni_idle_nx", nx, -1);
        chk("uni_idle_ny", ny, -1);

        run_frame(1, 1'b0);
        chk("step_6_5", res_val[5*W+6], 0);
        chk("step_7_5", res_val[5*W+7], 1020);
        chk("step_8_5", res_val[5*W+8], 1020);
        chk("step_count", frame_n, W*H);

        run_frame(2, 1'b0);
        chk("sat_10_9", res_val[9*W+10], 1023);
        chk("sat_9_9", res_val[9*W+9], 510);
        chk("sat_count", frame_n, W*H);

        run_frame(3, 1'b1);
        chk("ramp_1_0", res_val[1], 122);
        chk("ramp_2_0", res_val[2], 150);
        chk("ramp_1_0_cyc", res_cyc[1], 18);
        chk("ramp_2_0_cyc", res_cyc[2], 30);
        chk("ramp_5_5", res_val[5*W+5], 160);
        chk("ramp_count", frame_n, W*H);

        // Mid-frame reset, then restart from (0,0).
        rst = 1'b1; mode = 3;
        tick;
        rst = 1'b0; start_cyc = cyc; en = 1'b1;
        repeat (40) tick;
        chk("mid_pre_po", po, 178);
        rst = 1'b1;
        tick;
        chk("mid_rst_rv", rv, 0);
        chk("mid_rst_sync", sync, 0);
        chk("mid_rst_po", po, 0);
        chk("mid_rst_pox", pox, 0);
        chk("mid_rst_poy", poy, 0);
        chk("mid_rst_nx", nx, -1);
        chk("mid_rst_ny", ny, -1);
        rst = 1'b0; base = n_rv; start_cyc = cyc;
        for (int i = 0; i < 30; i++) begin
            tick;
            if (n_rv > base) break;
        end
        chk("restart_seen", (n_rv > base) ? 1 : 0, 1);
        chk("restart_x", last_x, 0);
        chk("restart_y", last_y, 0);
        chk("restart_val", last_val, 80);
        chk("restart_cyc", last_cyc, 9);
        en = 1'b0;
        tick;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/edge_detection_top.md
EDGE_DETECTION_TOP -- requirements
Module: edge_detection_top

Interface
REQ-001 Parameters SHALL be: IMG_W, default 640, image width in pixels; IMG_H, default 480, image height in pixels; CW, default 11, signed coordinate/result width.
REQ-002 Ports SHALL be: clk  in  1  single clock, all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 en  in  1  start/run enable.
REQ-005 waitrequest  in  1  high = pixel input not valid this cycle, stall.
REQ-006 pixel  in  8  unsigned pixel value at (next_pixel_x, next_pixel_y), sampled on the edge.
REQ-007 next_pixel_x, next_pixel_y  out  CW signed  coordinate of the pixel requested this cycle (may be -1 or IMG_W/IMG_H).
REQ-008 readValid  out  1  one-cycle pulse; pixel_out, pixel_out_x and pixel_out_y are valid.
REQ-009 pixel_out_x, pixel_out_y  out  CW signed  coordinate of the result.
REQ-010 pixel_out  out  CW signed  Sobel magnitude, range 0..1023.
REQ-011 sync  out  1  frame complete.

Function
REQ-012 For each output pixel (x,y), in raster order (x 0..IMG_W-1 inner, y 0..IMG_H-1 outer), the block SHALL fetch 9 neighbours in the order dy=-1..1 outer, dx=-1..1 inner, driving next_pixel=(x+dx,y+dy).
REQ-013 A fetch SHALL complete on an edge with waitrequest=0 and en=1; otherwise all state, including next_pixel, SHALL hold.
REQ-014 Out-of-image coordinates SHALL still be driven on next_pixel, but the sample SHALL be replaced by 0, ignoring pixel.
REQ-015 Gx SHALL use weights -1,0,+1 (dy=±1 rows) and -2,0,+2 (dy=0) over dx=-1,0,+1. Gy SHALL use weights -1,-2,-1 (dy=-1 row) and +1,+2,+1 (dy=+1 row), with y increasing downward.
REQ-016 Accumulators SHALL be at least 12-bit signed; pixel_out SHALL equal min(|Gx|+|Gy|, 1023).
REQ-017 On the edge completing the 9th fetch, the block SHALL register pixel_out, pixel_out_x=x and pixel_out_y=y, and assert readValid for exactly one cycle.
REQ-018 The first fetch of the next pixel SHALL proceed in that same readValid cycle; without stalls, throughput SHALL be one result per 9 cycles.
REQ-019 The state machine SHALL have three states: IDLE, FETCH and DONE.
REQ-020 IDLE SHALL drive next_pixel=(-1,-1). A completing fetch in IDLE (en=1, waitrequest=0) SHALL consume fetch 0 of (0,0) and move to FETCH.
REQ-021 FETCH SHALL move to DONE on the edge completing the last fetch of (IMG_W-1, IMG_H-1).
REQ-022 DONE SHALL assert sync, held while en=1; sync SHALL rise the cycle after the last readValid. en=0 sampled in DONE SHALL return to IDLE and clear sync.
REQ-023 en=0 during FETCH SHALL pause without loss; outputs SHALL be unchanged and readValid SHALL be 0 while paused.

Reset
REQ-024 rst SHALL take priority over all inputs, including mid-frame.
REQ-025 On reset: state=IDLE, readValid=0, sync=0, pixel_out=0, pixel_out_x=pixel_out_y=0, next_pixel=(-1,-1), accumulators and counters cleared.

Structure
REQ-026 A shared package SHALL hold IMG_W, IMG_H, CW, the state enum, the saturation limit 1023 and the kernel weight tables.
REQ-027 One sub-module, sobel_mac, SHALL hold the Gx/Gy accumulation, the absolute-value sum and the saturation. The top SHALL hold the coordinate counters and the FSM.

Verification
REQ-028 Uniform image, all pixels 100 -> (0,0)=600, (5,5)=0, (639,479)=600.
REQ-029 Vertical step, 0 for x<320 and 255 for x>=320 -> (318,100)=0, (319,100)=1020, (320,100)=1020.
REQ-030 Saturation: 255 where x+y>=20, else 0 -> (10,9)=1023 (|Gx|=|Gy|=765).
REQ-031 waitrequest high for 3 cycles during fetch 4 of (2,0) -> next_pixel holds (2,0), result value unchanged, readValid delayed by exactly 3 cycles.
REQ-032 Full frame, no stalls -> 307200 readValid pulses, the last at (639,479) on cycle 2764800 after start; sync=1 on the next cycle; en=0 -> IDLE and sync=0 on the following cycle.
REQ-033 rst asserted mid-frame -> next cycle all outputs at reset values; restart with en=1 re-begins at (0,0).
